i4201_clkgen: RTL
=================

I4201_CLKGEN -- requirements
Module: i4201_clkgen

Interface
REQ-001 SHALL have parameter CLK1_WIDTH, default 19: clk1 high time, in sysclk cycles.
REQ-002 SHALL have parameter GAP12, default 5: sysclk cycles from clk1 fall to clk2 rise.
REQ-003 SHALL have parameter CLK2_WIDTH, default 19: clk2 high time, in sysclk cycles.
REQ-004 SHALL have parameter GAP21, default 25: sysclk cycles from clk2 fall to the next clk1 rise.
REQ-005 SHALL have parameter POC_PERIODS, default 64: complete clock periods poc is held after reset release.
REQ-006 SHALL have port sysclk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port ext_reset_pad  input  1  asynchronous external reset request, active-high.
REQ-009 SHALL have port run  input  1  sysclk-synchronous run enable (1 = free-run).
REQ-010 SHALL have port step  input  1  sysclk-synchronous single-period request, rising-edge detected.
REQ-011 SHALL have port clk1_pad  output  1  MCS-4 phase-1 clock.
REQ-012 SHALL have port clk2_pad  output  1  MCS-4 phase-2 clock.
REQ-013 SHALL have port poc_pad  output  1  power-on clear to all MCS-4 chips.
REQ-014 SHALL have port period_start  output  1  one-sysclk pulse on the cycle clk1_pad rises.

Function
REQ-015 SHALL implement the phase FSM HALT, PH1, G12, PH2, G21 with one shared down-counter.
REQ-016 SHALL spend exactly CLK1_WIDTH, GAP12, CLK2_WIDTH and GAP21 sysclk cycles in PH1, G12, PH2 and G21; period = sum (default 68 = 1360 ns at 50 MHz).
REQ-017 SHALL drive clk1_pad high only in PH1 and clk2_pad high only in PH2, both from registers: never overlapping, no glitches.
REQ-018 SHALL take transitions PH1->G12->PH2->G21; from G21 go to PH1 if run=1 or a step is pending, otherwise to HALT.
REQ-019 SHALL in HALT hold both clocks low; go to PH1 on the cycle after run=1 or a step rising edge.
REQ-020 SHALL have a step issue exactly one full period; a step edge while not in HALT is latched and consumed at the next G21 exit; further edges before consumption are dropped.
REQ-021 SHALL assert period_start in the first PH1 cycle of every period.
REQ-022 SHALL pass ext_reset_pad through a two-flop synchronizer (reset value 1) before use.
REQ-023 SHALL hold poc_pad high while the synchronized ext reset is 1, then keep it high for POC_PERIODS further completed periods; it drops in the cycle a G21 exit completes the count.
REQ-024 SHALL reload the POC counter if the ext reset re-asserts mid-count; the clocks keep running throughout poc.
REQ-025 SHALL count only completed periods toward POC while halted (the count freezes in HALT).
REQ-026 SHALL treat any width parameter of 0 as an elaboration error.

Reset
REQ-027 SHALL on reset asynchronously force: FSM=G21 with counter=GAP21, clk1_pad=0, clk2_pad=0, poc_pad=1, period_start=0, synchronizer flops=1, step pending=0, POC counter=POC_PERIODS.
REQ-028 SHALL after reset release start the first clk1 rise GAP21 cycles later, provided the run enable is 1.

Configuration
REQ-029 SHALL with macro I4201_STEP_EN defined implement run/step/HALT exactly as in REQ-018..REQ-020.
REQ-030 SHALL with I4201_STEP_EN undefined omit HALT and step logic: run and step ports exist but are ignored, G21 always proceeds to PH1 (free-running).

Structure
REQ-031 SHALL put the phase-state enumeration and default width constants in a shared package mcs4_pkg.
REQ-032 SHALL implement the ext-reset synchronizer as sub-module mcs4_sync2 (2-flop, parameterized reset value).

Verification
REQ-033 SHALL verify defaults with run=1: clk1 high 19 cycles, 5 low-low, clk2 high 19, 25 low-low; period 68; never both high.
REQ-034 SHALL verify POC: reset release with ext_reset_pad=0 -> poc_pad falls exactly at end of period 64 (count periods via period_start).
REQ-035 SHALL verify ext_reset_pad pulsed high for 10 cycles mid-POC-count -> poc_pad stays high, then a fresh 64 periods are counted after the synchronized release.
REQ-036 SHALL verify, with I4201_STEP_EN, run=0 then step pulse -> exactly one period (one clk1 and one clk2 pulse), then HALT with clocks low.
REQ-037 SHALL verify run dropped during PH1 -> the current period completes in full and HALT is entered at the G21 exit; asynchronous reset asserted in PH2 -> clk2_pad low immediately.
REQ-038 SHALL verify, without I4201_STEP_EN, run=0 and step toggling -> clocks continue with period 68.

Source files
------------

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 clock generator types and default phase timing.
package mcs4_pkg;

  typedef enum logic [2:0] {
    HALT,
    PH1,
    G12,
    PH2,
    G21
  } phase_t;

  localparam int DEF_CLK1_WIDTH  = 19;
  localparam int DEF_GAP12       = 5;
  localparam int DEF_CLK2_WIDTH  = 19;
  localparam int DEF_GAP21       = 25;
  localparam int DEF_POC_PERIODS = 64;

endpackage

// File: rtl/mcs4_sync2.sv
// Two-flop synchronizer with a parameterized reset value.
module mcs4_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i4201_clkgen.sv
// MCS-4 two-phase clock and power-on-clear generator.
// Define I4201_STEP_EN to enable run/step control and the HALT state.
module i4201_clkgen
  import mcs4_pkg::*;
#(
  parameter int CLK1_WIDTH  = DEF_CLK1_WIDTH,
  parameter int GAP12       = DEF_GAP12,
  parameter int CLK2_WIDTH  = DEF_CLK2_WIDTH,
  parameter int GAP21       = DEF_GAP21,
  parameter int POC_PERIODS = DEF_POC_PERIODS
) (
  input  logic sysclk,
  input  logic reset,
  input  logic ext_reset_pad,
  input  logic run,
  input  logic step,
  output logic clk1_pad,
  output logic clk2_pad,
  output logic poc_pad,
  output logic period_start
);

  localparam int M1   = (CLK1_WIDTH > GAP12) ? CLK1_WIDTH : GAP12;
  localparam int M2   = (CLK2_WIDTH > GAP21) ? CLK2_WIDTH : GAP21;
  localparam int MAXW = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int PW   = $clog2(POC_PERIODS + 1) + 1;

  if (CLK1_WIDTH == 0 || GAP12 == 0 ||
      CLK2_WIDTH == 0 || GAP21 == 0) begin : g_bad_width
    $error("i4201_clkgen: phase widths must be nonzero");
  end

  logic          ext_sync;
  phase_t        state;
  phase_t        nstate;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ncnt;
  logic          last;
  logic          g21_exit;
  logic          go;
  logic [PW-1:0] poc_cnt;
  logic [PW-1:0] poc_n;
  logic          full;

  mcs4_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(sysclk),
    .rst(reset),
    .d  (ext_reset_pad),
    .q  (ext_sync)
  );

  assign last     = (cnt == CW'(1));
  assign g21_exit = (state == G21) && last;

`ifdef I4201_STEP_EN
  logic step_q;
  logic pend;
  logic step_edge;

  assign step_edge = step & ~step_q;
  assign go        = run | pend | step_edge;

  // One pending step at most; an edge on the exit cycle is used directly.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      step_q <= step;
      if (pend)
        pend <= ~g21_exit;
      else
        pend <= step_edge && (state != HALT) && !g21_exit;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = run ^ step;
  assign go         = 1'b1;
`endif

  always_comb begin
    nstate = state;
    ncnt   = cnt - CW'(1);
    unique case (state)
      HALT: begin
        ncnt = cnt;
        if (go) begin
          nstate = PH1;
          ncnt   = CW'(CLK1_WIDTH);
        end
      end
      PH1: if (last) begin
        nstate = G12;
        ncnt   = CW'(GAP12);
      end
      G12: if (last) begin
        nstate = PH2;
        ncnt   = CW'(CLK2_WIDTH);
      end
      PH2: if (last) begin
        nstate = G21;
        ncnt   = CW'(GAP21);
      end
      G21: if (last) begin
        nstate = go ? PH1 : HALT;
        ncnt   = go ? CW'(CLK1_WIDTH) : '0;
      end
      default: begin
        nstate = G21;
        ncnt   = CW'(GAP21);
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state        <= G21;
      cnt          <= CW'(GAP21);
      clk1_pad     <= 1'b0;
      clk2_pad     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= nstate;
      cnt          <= ncnt;
      clk1_pad     <= (nstate == PH1);
      clk2_pad     <= (nstate == PH2);
      period_start <= (nstate == PH1) && (state != PH1);
    end
  end

  // Only periods that began after ext reset released count toward POC.
  always_comb begin
    poc_n = poc_cnt;
    if (ext_sync)
      poc_n = PW'(POC_PERIODS);
    else if (g21_exit && full && poc_cnt != '0)
      poc_n = poc_cnt - PW'(1);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      poc_cnt <= PW'(POC_PERIODS);
      poc_pad <= 1'b1;
      full    <= 1'b0;
    end else begin
      poc_cnt <= poc_n;
      poc_pad <= ext_sync | (poc_n != '0);
      full    <= ~ext_sync & (full | period_start);
    end
  end

endmodule
